// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
//
// Credit-accumulating vending state machine fed by debounced push-button
// levels. Each rising edge of a level becomes exactly one event. Coins add to
// credit, buy dispenses one item and returns any change, and cancel refunds
// the whole credit.
//
// Parameters:
//   PRICE       item price in cents (must be <= MAX_CREDIT)
//   MAX_CREDIT  highest credit held, in cents
//   CREDIT_W    width of credit/change buses (2^CREDIT_W > MAX_CREDIT + 25)
//
// Ports:
//   clk_in        board clock
//   rst           asynchronous active-high reset
//   coin5/10/25   debounced coin levels
//   buy, cancel   debounced request levels
//   credit        current credit in cents (registered)
//   dispense      one-cycle pulse, one item released
//   change        change amount, non-zero only while change_valid is high
//   change_valid  one-cycle pulse qualifying change
//   coin_reject   one-cycle pulse, coin(s) of the previous sample refused
// -----------------------------------------------------------------------------
module vending_controller #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 95,
    parameter int CREDIT_W   = 7
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                coin25,
    input  logic                buy,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    // Bit positions inside the packed input vector
    localparam int N_IN     = 5;
    localparam int IDX_C5   = 0;
    localparam int IDX_C10  = 1;
    localparam int IDX_C25  = 2;
    localparam int IDX_BUY  = 3;
    localparam int IDX_CNCL = 4;

    localparam logic [CREDIT_W-1:0] COIN5_W  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] COIN10_W = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] COIN25_W = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] PRICE_W  = CREDIT_W'(PRICE);
    // One extra bit so credit + simultaneous coins can never wrap before compare
    localparam logic [CREDIT_W:0]   MAX_W    = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [CREDIT_W-1:0] change_reg;
    logic                dispense_reg;
    logic                change_valid_reg;
    logic                coin_reject_reg;
    logic [N_IN-1:0]     prev_reg;

    logic [N_IN-1:0]     level_vec;
    logic [N_IN-1:0]     event_vec;
    logic [CREDIT_W-1:0] coin_sum;
    logic [CREDIT_W:0]   sum_wide;
    logic [CREDIT_W-1:0] remainder;
    logic                any_coin;
    logic                coin_fits;
    logic                buy_ok;

    assign level_vec = {cancel, buy, coin25, coin10, coin5};

    // Rising-edge detect per input; prev resets to 1 so a level already high
    // at reset release must drop and rise again before it counts.
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_edge
            assign event_vec[gi] = level_vec[gi] & ~prev_reg[gi];
        end
    endgenerate

    always_comb begin
        coin_sum = '0;
        if (event_vec[IDX_C5])  coin_sum = coin_sum + COIN5_W;
        if (event_vec[IDX_C10]) coin_sum = coin_sum + COIN10_W;
        if (event_vec[IDX_C25]) coin_sum = coin_sum + COIN25_W;
    end

    assign any_coin  = |event_vec[IDX_C25:IDX_C5];
    assign sum_wide  = {1'b0, credit_reg} + {1'b0, coin_sum};
    assign coin_fits = (sum_wide <= MAX_W);
    assign remainder = credit_reg - PRICE_W;
    assign buy_ok    = (credit_reg >= PRICE_W);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            change_reg       <= '0;
            dispense_reg     <= 1'b0;
            change_valid_reg <= 1'b0;
            coin_reject_reg  <= 1'b0;
            prev_reg         <= '1;
        end else begin
            prev_reg         <= level_vec;
            // Pulses default low so each lasts exactly one cycle
            dispense_reg     <= 1'b0;
            change_valid_reg <= 1'b0;
            change_reg       <= '0;
            coin_reject_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_COLLECT: begin
                    // In IDLE credit is 0, so buy can never qualify and cancel
                    // has nothing to refund: both are simply ignored there.
                    if (state_reg == ST_COLLECT && event_vec[IDX_CNCL]) begin
                        state_reg        <= ST_CHANGE;
                        change_valid_reg <= 1'b1;
                        change_reg       <= credit_reg;
                        coin_reject_reg  <= any_coin;
                    end else if (state_reg == ST_COLLECT && event_vec[IDX_BUY] && buy_ok) begin
                        state_reg       <= ST_VEND;
                        dispense_reg    <= 1'b1;
                        coin_reject_reg <= any_coin;
                    end else if (any_coin) begin
                        if (coin_fits) begin
                            credit_reg <= sum_wide[CREDIT_W-1:0];
                            state_reg  <= ST_COLLECT;
                        end else begin
                            coin_reject_reg <= 1'b1;
                        end
                    end
                end

                ST_VEND: begin
                    coin_reject_reg <= any_coin;
                    credit_reg      <= remainder;
                    if (remainder != '0) begin
                        state_reg        <= ST_CHANGE;
                        change_valid_reg <= 1'b1;
                        change_reg       <= remainder;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end

                ST_CHANGE: begin
                    coin_reject_reg <= any_coin;
                    credit_reg      <= '0;
                    state_reg       <= ST_IDLE;
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    credit_reg <= '0;
                end
            endcase
        end
    end

    assign credit       = credit_reg;
    assign dispense     = dispense_reg;
    assign change       = change_reg;
    assign change_valid = change_valid_reg;
    assign coin_reject  = coin_reject_reg;

endmodule

// File: tb/tb_vending_controller.sv
// -----------------------------------------------------------------------------
// tb_vending_controller
//
// Directed steps followed by a randomized run. Expected outputs come from a
// timeline model: each purchase or refund schedules the outputs of the cycles
// that follow it, and coins are accepted against a plain integer credit.
// -----------------------------------------------------------------------------
module tb_vending_controller;

    localparam int PRICE      = 15;
    localparam int MAX_CREDIT = 95;
    localparam int CREDIT_W   = 7;

    logic                clk_in = 1'b0;
    logic                rst    = 1'b1;
    logic                coin5  = 1'b0;
    logic                coin10 = 1'b0;
    logic                coin25 = 1'b0;
    logic                buy    = 1'b0;
    logic                cancel = 1'b0;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic                coin_reject;

    vending_controller #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .coin5        (coin5),
        .coin10       (coin10),
        .coin25       (coin25),
        .buy          (buy),
        .cancel       (cancel),
        .credit       (credit),
        .dispense     (dispense),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    typedef struct {
        int credit;
        bit disp;
        bit cv;
        int chg;
    } snap_t;

    snap_t q[$];        // outputs already committed for upcoming cycles
    bit    m_prev[5];   // coin5, coin10, coin25, buy, cancel
    int    e_credit;
    bit    e_disp;
    bit    e_cv;
    int    e_chg;
    bit    e_rej;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 5; i++) m_prev[i] = 1'b1;
        e_credit = 0; e_disp = 0; e_cv = 0; e_chg = 0; e_rej = 0;
    endtask

    task automatic model_edge();
        bit lv[5];
        bit ev[5];
        int sum;
        bit any_coin;
        snap_t s;
        lv[0] = coin5; lv[1] = coin10; lv[2] = coin25; lv[3] = buy; lv[4] = cancel;
        for (int i = 0; i < 5; i++) begin
            ev[i]     = lv[i] && !m_prev[i];
            m_prev[i] = lv[i];
        end
        sum      = (ev[0] ? 5 : 0) + (ev[1] ? 10 : 0) + (ev[2] ? 25 : 0);
        any_coin = (sum > 0);
        e_disp = 0; e_cv = 0; e_chg = 0; e_rej = 0;
        if (q.size() > 0) begin
            // Busy finishing a purchase/refund: coins refused, requests dropped
            s        = q.pop_front();
            e_credit = s.credit;
            e_disp   = s.disp;
            e_cv     = s.cv;
            e_chg    = s.chg;
            e_rej    = any_coin;
        end else if (ev[4] && e_credit > 0) begin
            e_cv  = 1;
            e_chg = e_credit;
            e_rej = any_coin;
            q.push_back('{0, 1'b0, 1'b0, 0});
        end else if (ev[3] && e_credit >= PRICE) begin
            e_disp = 1;
            e_rej  = any_coin;
            if (e_credit - PRICE > 0)
                q.push_back('{e_credit - PRICE, 1'b0, 1'b1, e_credit - PRICE});
            q.push_back('{0, 1'b0, 1'b0, 0});
        end else if (any_coin) begin
            if (e_credit + sum <= MAX_CREDIT) e_credit = e_credit + sum;
            else                              e_rej    = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("credit",       int'(credit),       e_credit);
        chk("dispense",     int'(dispense),     int'(e_disp));
        chk("change_valid", int'(change_valid), int'(e_cv));
        chk("change",       int'(change),       e_chg);
        chk("coin_reject",  int'(coin_reject),  int'(e_rej));
        if (e_disp) $display("cyc=%0d dispense credit=%0d", cyc, e_credit);
        if (e_cv)   $display("cyc=%0d change=%0d", cyc, e_chg);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            cyc++;
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic set_in(input bit c5, input bit c10, input bit c25,
                          input bit b, input bit cn);
        coin5 = c5; coin10 = c10; coin25 = c25; buy = b; cancel = cn;
    endtask

    // Asynchronous reset: checked before any clock edge, held for two edges
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        $display("cyc=%0d reset released", cyc);
    endtask

    // One clean rising edge followed by a low cycle
    task automatic tap(input bit c5, input bit c10, input bit c25,
                       input bit b, input bit cn);
        set_in(c5, c10, c25, b, cn);
        step(1);
        set_in(0, 0, 0, 0, 0);
        step(1);
    endtask

    initial begin
        bit lv[5];
        model_reset();
        #2;
        do_reset();
        chk("reset_credit", int'(credit), 0);
        step(2);

        // coin10, coin5, buy at exact price
        set_in(0, 1, 0, 0, 0); step(1); chk("c10_credit", int'(credit), 10);
        set_in(0, 0, 0, 0, 0); step(1);
        set_in(1, 0, 0, 0, 0); step(1); chk("c5_credit", int'(credit), 15);
        set_in(0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 1, 0); step(1); chk("buy15_disp", int'(dispense), 1);
        set_in(0, 0, 0, 0, 0); step(1);
        chk("buy15_idle_credit", int'(credit), 0);
        chk("buy15_no_change", int'(change_valid), 0);
        step(2);

        // coin25 then buy -> change 10
        tap(0, 0, 1, 0, 0);
        set_in(0, 0, 0, 1, 0); step(1); chk("buy25_disp", int'(dispense), 1);
        set_in(0, 0, 0, 0, 0); step(1);
        chk("buy25_cv", int'(change_valid), 1);
        chk("buy25_change", int'(change), 10);
        step(1); chk("buy25_after", int'(credit), 0);

        // coin10 then cancel; then buy with too little credit
        tap(0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 1); step(1);
        chk("cancel_cv", int'(change_valid), 1);
        chk("cancel_change", int'(change), 10);
        chk("cancel_no_disp", int'(dispense), 0);
        set_in(0, 0, 0, 0, 0); step(2);
        tap(1, 0, 0, 0, 0);
        set_in(0, 0, 0, 1, 0); step(1);
        chk("buy_low_credit", int'(credit), 5);
        chk("buy_low_disp", int'(dispense), 0);
        set_in(0, 0, 0, 0, 0); step(1);
        tap(0, 0, 0, 0, 1); step(1);

        // credit limit
        tap(0, 0, 1, 0, 0); tap(0, 0, 1, 0, 0); tap(0, 0, 1, 0, 0);
        tap(0, 1, 0, 0, 0); tap(1, 0, 0, 0, 0);
        chk("build90", int'(credit), 90);
        set_in(0, 1, 0, 0, 0); step(1);
        chk("over_reject", int'(coin_reject), 1);
        chk("over_credit", int'(credit), 90);
        set_in(0, 0, 0, 0, 0); step(1);
        chk("reject_one_cycle", int'(coin_reject), 0);
        tap(1, 0, 0, 0, 0);
        chk("credit_95", int'(credit), 95);
        tap(0, 0, 0, 0, 1); step(1);
        tap(0, 0, 1, 0, 0); tap(0, 0, 1, 0, 0);
        set_in(1, 1, 1, 0, 0); step(1);
        chk("triple_coin", int'(credit), 90);
        set_in(0, 0, 0, 0, 0); step(1);
        tap(0, 0, 0, 0, 1); step(1);

        // held coin counts once; cancel + coin in same cycle
        set_in(0, 0, 1, 0, 0); step(1000);
        chk("held_coin", int'(credit), 25);
        set_in(0, 0, 0, 0, 0); step(1);
        set_in(1, 0, 0, 0, 1); step(1);
        chk("cancel_coin_cv", int'(change_valid), 1);
        chk("cancel_coin_change", int'(change), 25);
        chk("cancel_coin_reject", int'(coin_reject), 1);
        set_in(0, 0, 0, 0, 0); step(2);

        // coin held across reset release; reset during VEND
        set_in(0, 0, 1, 0, 0);
        do_reset();
        step(3);
        chk("held_over_reset", int'(credit), 0);
        set_in(0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 1, 0, 0); step(1);
        chk("rearmed_coin", int'(credit), 25);
        set_in(0, 0, 0, 1, 0); step(1);
        chk("vend_before_rst", int'(dispense), 1);
        #1;
        do_reset();
        chk("rst_vend_disp", int'(dispense), 0);
        chk("rst_vend_credit", int'(credit), 0);
        set_in(0, 0, 0, 0, 0); step(2);

        // randomized run with one mid-run reset
        for (int i = 0; i < 5; i++) lv[i] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 9) < ((i >= 3) ? 2 : 3)) lv[i] = ~lv[i];
            set_in(lv[0], lv[1], lv[2], lv[3], lv[4]);
            if (n == 1500) do_reset();
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
# vending_controller

Credit-accumulating vending state machine that sits directly downstream of the push-button debounce stages. It takes the debounced coin, buy and cancel levels and turns each rising edge into exactly one event. It then accumulates credit, dispenses one item per purchase, and returns change on a purchase or on cancel. All logic runs in the board clock domain.

## Interface
- PRICE, default 15: item price in cents; must be ≤ MAX_CREDIT.
- MAX_CREDIT, default 95: highest credit the block will hold, in cents.
- CREDIT_W, default 7: width of the credit and change buses; must satisfy 2^CREDIT_W > MAX_CREDIT + 25.

Ports:
- clk_in  input  1  board clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- coin5  input  1  debounced level, 5-cent coin.
- coin10  input  1  debounced level, 10-cent coin.
- coin25  input  1  debounced level, 25-cent coin.
- buy  input  1  debounced level, purchase request.
- cancel  input  1  debounced level, refund request.
- credit  output  CREDIT_W  current credit in cents (registered).
- dispense  output  1  one-cycle pulse; one item released.
- change  output  CREDIT_W  change amount; valid only while change_valid=1, otherwise 0.
- change_valid  output  1  one-cycle pulse qualifying change.
- coin_reject  output  1  one-cycle pulse; the coin(s) of this cycle were refused.

## Operation
- Edge detection: one prev register per input (coin5, coin10, coin25, buy, cancel). event_x = x & ~prev_x, and prev_x <= x every cycle.
  - A level held high for many cycles yields exactly one event.
  - All prev registers reset to 1, so an input already high at reset release must fall and rise again before it counts.
- Coin sum per cycle: coin_sum = 5·e5 + 10·e10 + 25·e25, evaluated at CREDIT_W bits. Simultaneous coin events are summed.
- Coin acceptance: coins are accepted only in IDLE or COLLECT, and only if credit + coin_sum ≤ MAX_CREDIT.
  - If that limit would be exceeded, all coins of that cycle are refused, credit is unchanged, and coin_reject=1.
  - Coin events in VEND or CHANGE are always refused with coin_reject=1.
- States:
  - IDLE: credit=0. buy and cancel events are ignored. An accepted coin sets credit=coin_sum and moves to COLLECT.
  - COLLECT: event priority within a cycle is cancel > buy > coins.
    - cancel event -> CHANGE; any coin event in the same cycle is refused with coin_reject=1.
    - buy event with credit ≥ PRICE -> VEND; coins in the same cycle are refused.
    - buy event with credit < PRICE is ignored, and coins in that cycle are processed normally.
    - Otherwise, accepted coins add to credit.
  - VEND: lasts one cycle. dispense=1 and credit <= credit − PRICE. Next state is CHANGE if the remainder is > 0, else IDLE.
  - CHANGE: lasts one cycle. change_valid=1 and change=credit, then credit <= 0 and the state moves to IDLE.
- Buy and cancel events arriving in VEND or CHANGE are discarded, not queued.
- dispense, change_valid and coin_reject are never high for more than one consecutive cycle per event.

## Timing
- Reset (asynchronous, effective immediately):
  - state=IDLE, credit=0, change=0.
  - dispense=0, change_valid=0, coin_reject=0.
  - All prev registers=1.
- All outputs are registered, decoded from the state and datapath registers.
- Input first sampled high at edge N:
  - the event is processed at edge N;
  - credit, state and coin_reject reflect it in cycle N+1.
- Purchase latency:
  - buy sampled at edge N -> dispense high in cycle N+1;
  - change_valid high in cycle N+2 if there is a remainder;
  - IDLE in cycle N+2 (no remainder) or N+3 (with remainder).
- Cancel latency: cancel sampled at edge N -> change_valid high in cycle N+1 -> IDLE in cycle N+2.
- Reset asserted mid-VEND or mid-CHANGE aborts the operation with no pulse, and credit is lost.
- The block takes no throughput assumption on inputs: back-to-back events on consecutive cycles are legal, subject to the state rules above.

## Test plan
- coin10 edge, then coin5 edge, then buy edge (PRICE=15) -> credit 10, then 15; dispense one cycle; no change_valid; returns to IDLE with credit 0.
- coin25 edge, then buy edge -> dispense in cycle N+1, then change_valid with change=10 in cycle N+2; credit 0 afterwards.
- coin10, then cancel -> change_valid with change=10; no dispense. buy with credit 5 -> ignored, credit stays 5.
- Credit 90, coin10 edge -> coin_reject pulse, credit stays 90. Then coin5 -> credit 95. Then coin5, coin10 and coin25 in the same cycle from credit 50 -> credit 90.
- coin25 held high 1000 cycles -> credit 25 exactly once. cancel and coin5 rising in the same cycle in COLLECT -> refund of prior credit plus coin_reject.
- coin25 held high across reset release -> no credit until it falls and rises again. rst asserted during VEND -> no dispense pulse; credit=0 immediately.
